// File: rtl/wb_fetch_burst_pkg.sv
// Shared types for the Wishbone block-fetch unit: FSM state encoding and
// classification of a single slave response.
package wb_fetch_burst_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ISSUE     = 2'd1,
    ST_DRAIN_RTY = 2'd2,
    ST_DRAIN_ERR = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    RSP_NONE = 2'd0,
    RSP_ACK  = 2'd1,
    RSP_RTY  = 2'd2,
    RSP_ERR  = 2'd3
  } rsp_e;

  // A slave asserting several response lines at once is faulty; the most
  // severe one wins and any accompanying ack is discarded.
  function automatic rsp_e rsp_class(input logic ack, input logic rty, input logic err);
    if (err)      return RSP_ERR;
    else if (rty) return RSP_RTY;
    else if (ack) return RSP_ACK;
    else          return RSP_NONE;
  endfunction

endpackage

// File: rtl/wb_outstanding.sv
// Up/down counter of in-flight bus requests; shared by the fetch and store
// engines to throttle the strobe at MAXOUT.
module wb_outstanding #(
  parameter int MAXOUT = 4,
  parameter int OBITS  = 3
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic inc_i,
  input  logic dec_i,
  output logic full_o,
  output logic empty_o
);

  localparam logic [OBITS-1:0] ONE  = OBITS'(1);
  localparam logic [OBITS-1:0] FULL = OBITS'(MAXOUT);

  logic [OBITS-1:0] count_q, count_d;

  always_comb begin
    // NOTE: assign the default first so every path writes count_d; otherwise
    // synthesis infers a latch.
    count_d = count_q;
    if (inc_i && !dec_i)      count_d = count_q + ONE;
    else if (dec_i && !inc_i) count_d = count_q - ONE;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    // NOTE: non-blocking assignments for state, so every register samples the
    // pre-edge values regardless of block ordering.
    if (rst_i) count_q <= '0;
    else       count_q <= count_d;
  end

  assign full_o  = (count_q == FULL);
  assign empty_o = (count_q == '0);

endmodule

// File: rtl/wb_fetch_burst.sv
// Pipelined Wishbone block fetch with bounded outstanding requests, retry
// replay and error abort; streams acked words in order to a sink.
module wb_fetch_burst
  import wb_fetch_burst_pkg::*;
#(
  parameter int ABITS   = 9,
  parameter int WIDTH   = 32,
  parameter int LBITS   = 8,
  parameter int MAXOUT  = 4,
  parameter int OBITS   = 3,
  parameter int RETRIES = 3,
  parameter int RBITS   = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             fetch_i,
  input  logic [ABITS-1:0] base_i,
  input  logic [LBITS-1:0] count_i,
  output logic             busy_o,
  output logic             ready_o,
  output logic             error_o,
  output logic             cyc_o,
  output logic             stb_o,
  output logic             we_o,
  output logic [ABITS-1:0] adr_o,
  input  logic             ack_i,
  input  logic             wat_i,
  input  logic             rty_i,
  input  logic             err_i,
  input  logic [WIDTH-1:0] dat_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o,
  output logic             last_o
);

  localparam logic [ABITS-1:0] ONE_A     = ABITS'(1);
  localparam logic [LBITS-1:0] ONE_L     = LBITS'(1);
  localparam logic [RBITS-1:0] ONE_R     = RBITS'(1);
  localparam logic [RBITS-1:0] RETRY_MAX = RBITS'(RETRIES);

  state_e           state_q,  state_d;
  logic [ABITS-1:0] base_q,   base_d;
  logic [LBITS-1:0] count_q,  count_d;
  logic [ABITS-1:0] adr_q,    adr_d;
  logic [LBITS-1:0] issued_q, issued_d;
  logic [LBITS-1:0] acked_q,  acked_d;
  logic [RBITS-1:0] retry_q,  retry_d;
  logic             error_q,  error_d;
  logic             ready_q,  ready_d;
  logic             valid_q,  valid_d;
  logic             last_q,   last_d;
  logic [WIDTH-1:0] data_q,   data_d;

  logic out_full, out_empty;
  logic accept;
  rsp_e rsp;

  assign cyc_o  = (state_q != ST_IDLE);
  assign busy_o = cyc_o;
  assign stb_o  = (state_q == ST_ISSUE) && (issued_q != count_q) && !out_full;
  assign accept = stb_o && !wat_i;
  // Responses only count while a cycle is open and something is in flight.
  assign rsp    = (cyc_o && !out_empty) ? rsp_class(ack_i, rty_i, err_i) : RSP_NONE;

  wb_outstanding #(
    .MAXOUT (MAXOUT),
    .OBITS  (OBITS)
  ) u_outstanding (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .inc_i   (accept),
    .dec_i   (rsp != RSP_NONE),
    .full_o  (out_full),
    .empty_o (out_empty)
  );

  always_comb begin
    state_d  = state_q;
    base_d   = base_q;
    count_d  = count_q;
    adr_d    = adr_q;
    issued_d = issued_q;
    acked_d  = acked_q;
    retry_d  = retry_q;
    error_d  = error_q;
    data_d   = data_q;
    ready_d  = 1'b0;
    valid_d  = 1'b0;
    last_d   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (fetch_i) begin
          error_d = 1'b0;
          if (count_i == '0) begin
            ready_d = 1'b1;
          end else begin
            state_d  = ST_ISSUE;
            base_d   = base_i;
            count_d  = count_i;
            adr_d    = base_i;
            issued_d = '0;
            acked_d  = '0;
            retry_d  = '0;
          end
        end
      end

      ST_ISSUE: begin
        if (accept) begin
          adr_d    = adr_q + ONE_A;
          issued_d = issued_q + ONE_L;
        end
        unique case (rsp)
          RSP_ERR: state_d = ST_DRAIN_ERR;
          RSP_RTY: begin
            if (retry_q == RETRY_MAX) begin
              state_d = ST_DRAIN_ERR;
            end else begin
              retry_d = retry_q + ONE_R;
              state_d = ST_DRAIN_RTY;
            end
          end
          RSP_ACK: begin
            data_d  = dat_i;
            valid_d = 1'b1;
            acked_d = acked_q + ONE_L;
            if (acked_q + ONE_L == count_q) begin
              last_d  = 1'b1;
              ready_d = 1'b1;
              state_d = ST_IDLE;
            end
          end
          default: ;
        endcase
      end

      ST_DRAIN_RTY: begin
        // Late responses are dropped; replay resumes at the first un-acked word.
        if (out_empty) begin
          issued_d = acked_q;
          adr_d    = base_q + ABITS'(acked_q);
          state_d  = ST_ISSUE;
        end
      end

      ST_DRAIN_ERR: begin
        if (out_empty) begin
          error_d = 1'b1;
          ready_d = 1'b1;
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      base_q   <= '0;
      count_q  <= '0;
      adr_q    <= '0;
      issued_q <= '0;
      acked_q  <= '0;
      retry_q  <= '0;
      error_q  <= 1'b0;
      ready_q  <= 1'b0;
      valid_q  <= 1'b0;
      last_q   <= 1'b0;
      data_q   <= '0;
    end else begin
      state_q  <= state_d;
      base_q   <= base_d;
      count_q  <= count_d;
      adr_q    <= adr_d;
      issued_q <= issued_d;
      acked_q  <= acked_d;
      retry_q  <= retry_d;
      error_q  <= error_d;
      ready_q  <= ready_d;
      valid_q  <= valid_d;
      last_q   <= last_d;
      data_q   <= data_d;
    end
  end

  assign we_o    = 1'b0;
  assign adr_o   = adr_q;
  assign error_o = error_q;
  assign ready_o = ready_q;
  assign valid_o = valid_q;
  assign last_o  = last_q;
  assign data_o  = data_q;

endmodule

// File: tb/tb_wb_fetch_burst.sv
// Randomised bench for wb_fetch_burst: an in-order SRAM slave with variable
// latency, stalls and injected retry/error responses, checked against the
// word sequence each fetch should deliver.
module tb_wb_fetch_burst;

  localparam int ABITS  = 9;
  localparam int WIDTH  = 32;
  localparam int LBITS  = 8;
  localparam int MAXOUT = 4;
  localparam int DEPTH  = 1 << ABITS;

  logic             clk_i   = 1'b0;
  logic             rst_i   = 1'b1;
  logic             fetch_i = 1'b0;
  logic [ABITS-1:0] base_i  = '0;
  logic [LBITS-1:0] count_i = '0;
  logic             ack_i   = 1'b0;
  logic             wat_i   = 1'b0;
  logic             rty_i   = 1'b0;
  logic             err_i   = 1'b0;
  logic [WIDTH-1:0] dat_i   = '0;
  logic             busy_o, ready_o, error_o, cyc_o, stb_o, we_o;
  logic             valid_o, last_o;
  logic [ABITS-1:0] adr_o;
  logic [WIDTH-1:0] data_o;

  wb_fetch_burst dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .fetch_i (fetch_i),
    .base_i  (base_i),
    .count_i (count_i),
    .busy_o  (busy_o),
    .ready_o (ready_o),
    .error_o (error_o),
    .cyc_o   (cyc_o),
    .stb_o   (stb_o),
    .we_o    (we_o),
    .adr_o   (adr_o),
    .ack_i   (ack_i),
    .wat_i   (wat_i),
    .rty_i   (rty_i),
    .err_i   (err_i),
    .dat_i   (dat_i),
    .valid_o (valid_o),
    .data_o  (data_o),
    .last_o  (last_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [ABITS-1:0] a;
    int               due;
  } req_t;

  logic [WIDTH-1:0] mem [DEPTH];
  int checks = 0;
  int errors = 0;

  // Slave behaviour for the next fetch.
  int lat_lo, lat_hi, wat_pct, wat_adr, wat_len, wat_done, err_idx;
  int rty_idx[$];
  bit rty_always;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_cfg(input int lo, input int hi, input int wp);
    lat_lo = lo; lat_hi = hi; wat_pct = wp;
    wat_adr = -1; wat_len = 0; wat_done = 0;
    err_idx = -1; rty_idx.delete(); rty_always = 1'b0;
  endtask

  task automatic clear_bus();
    ack_i = 1'b0; rty_i = 1'b0; err_i = 1'b0; wat_i = 1'b0; fetch_i = 1'b0;
  endtask

  task automatic run_fetch(input logic [ABITS-1:0] base, input logic [LBITS-1:0] cnt,
                           input string tn, input int abort_words, input bit consec,
                           output int max_out);
    req_t             pend[$];
    req_t             r;
    logic [ABITS-1:0] acc_adr[$];
    int               acc_cyc[$];
    logic [WIDTH-1:0] got[$];
    logic [ABITS-1:0] ra[$];
    logic [ABITS-1:0] ea, a, prev_adr, wa;
    bit               used[int];
    bit               err_used, exp_err, done, prev_stall, prev_fault, is_rty, clean;
    int               exp_k, last_cnt, viol, n, bad;

    max_out = 0; err_used = 0; done = 0; prev_stall = 0; prev_fault = 0;
    last_cnt = 0; viol = 0; prev_adr = '0;
    ea = base + ABITS'(err_idx);
    foreach (rty_idx[i]) ra.push_back(base + ABITS'(rty_idx[i]));
    clean = (err_idx < 0) && (rty_idx.size() == 0);
    if (err_idx >= 0)                           begin exp_err = 1; exp_k = err_idx;    end
    else if (rty_always && rty_idx.size() > 0)  begin exp_err = 1; exp_k = rty_idx[0]; end
    else                                        begin exp_err = 0; exp_k = int'(cnt);  end

    @(negedge clk_i);
    fetch_i = 1'b1; base_i = base; count_i = cnt;
    @(negedge clk_i);
    fetch_i = 1'b0; base_i = ABITS'($urandom); count_i = LBITS'($urandom);
    check({tn, " start_cyc_stb_busy"}, {cyc_o, stb_o, busy_o}, 3'b111);
    check({tn, " start_adr"}, adr_o, base);

    for (n = 0; n < 4000; n++) begin
      if (n > 0) @(negedge clk_i);
      clear_bus();
      if (valid_o) begin
        got.push_back(data_o);
        last_cnt += int'(last_o);
      end
      if (ready_o) begin
        check({tn, " ready_last"}, last_o, !exp_err);
        check({tn, " ready_error"}, error_o, exp_err);
        check({tn, " ready_cyc_busy"}, {cyc_o, busy_o}, 2'b00);
        done = 1;
        break;
      end
      if (abort_words > 0 && valid_o && got.size() >= abort_words) begin
        #1 rst_i = 1'b1;
        #1;
        check({tn, " async_reset_ctrl"}, {cyc_o, stb_o, valid_o, busy_o, ready_o, last_o, error_o}, 7'd0);
        check({tn, " async_reset_adr_data"}, {adr_o, data_o}, '0);
        @(negedge clk_i);
        rst_i = 1'b0;
        return;
      end
      if (prev_stall && !prev_fault) begin
        check({tn, " wat_hold_stb"}, stb_o, 1'b1);
        check({tn, " wat_hold_adr"}, adr_o, prev_adr);
      end
      if (stb_o && pend.size() >= MAXOUT) viol++;

      dat_i = WIDTH'($urandom);
      prev_fault = 0;
      if (pend.size() > 0 && pend[0].due <= n) begin
        r = pend.pop_front();
        a = r.a;
        is_rty = 0;
        foreach (ra[i]) if (ra[i] == a) is_rty = 1;
        if (err_idx >= 0 && a == ea && !err_used) begin
          err_i = 1'b1; err_used = 1; prev_fault = 1;
          ack_i = 1'($urandom_range(0, 1));
        end else if (is_rty && (rty_always || !used.exists(int'(a)))) begin
          rty_i = 1'b1; used[int'(a)] = 1; prev_fault = 1;
          ack_i = 1'($urandom_range(0, 1));
        end else begin
          ack_i = 1'b1;
          dat_i = mem[a];
        end
      end

      if (wat_adr >= 0 && stb_o && int'(adr_o) == wat_adr && wat_done < wat_len) begin
        wat_i = 1'b1;
        wat_done++;
      end else begin
        wat_i = ($urandom_range(0, 99) < wat_pct);
      end
      prev_stall = stb_o && wat_i;
      prev_adr   = adr_o;
      if (stb_o && !wat_i) begin
        r.a = adr_o;
        r.due = n + int'($urandom_range(lat_lo, lat_hi));
        pend.push_back(r);
        acc_adr.push_back(adr_o);
        acc_cyc.push_back(n);
      end
      if (pend.size() > max_out) max_out = pend.size();
      if (busy_o && $urandom_range(0, 9) == 0) begin
        fetch_i = 1'b1; base_i = ABITS'($urandom); count_i = LBITS'($urandom);
      end
    end

    if (!done) check({tn, " timeout"}, 1'b0, 1'b1);
    clear_bus();
    check({tn, " words"}, got.size(), exp_k);
    for (int i = 0; i < got.size() && i < exp_k; i++) begin
      wa = base + ABITS'(i);
      check($sformatf("%s word%0d", tn, i), got[i], mem[wa]);
    end
    check({tn, " last_count"}, last_cnt, exp_err ? 0 : 1);
    check({tn, " outstanding_limit"}, viol, 0);
    if (clean) begin
      bad = 0;
      foreach (acc_adr[i]) if (acc_adr[i] != base + ABITS'(i)) bad++;
      check({tn, " adr_count"}, acc_adr.size(), int'(cnt));
      check({tn, " adr_sequence"}, bad, 0);
      if (consec && acc_cyc.size() > 0)
        check({tn, " back_to_back"}, acc_cyc[acc_cyc.size()-1] - acc_cyc[0], int'(cnt) - 1);
    end
    @(negedge clk_i);
    check({tn, " ready_pulse_end"}, {ready_o, valid_o}, 2'b00);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "global timeout");
  end

  initial begin
    int mo, cnt, mode;
    for (int i = 0; i < DEPTH; i++) mem[i] = WIDTH'($urandom);
    set_cfg(1, 1, 0);

    #12;
    check("reset_ctrl", {cyc_o, stb_o, we_o, busy_o, ready_o, error_o, valid_o, last_o}, 8'd0);
    check("reset_adr_data", {adr_o, data_o}, '0);
    @(negedge clk_i);
    rst_i = 1'b0;

    set_cfg(1, 1, 0);
    run_fetch(9'h010, 8'd8, "nominal", 0, 1, mo);

    set_cfg(6, 6, 0);
    run_fetch(9'h010, 8'd8, "slow", 0, 0, mo);
    check("slow max_outstanding", mo, MAXOUT);

    set_cfg(1, 1, 0);
    wat_adr = 9'h012; wat_len = 3;
    run_fetch(9'h010, 8'd8, "stall", 0, 0, mo);
    check("stall cycles", wat_done, 3);

    set_cfg(3, 3, 0);
    rty_idx.push_back(4);
    run_fetch(9'h010, 8'd8, "retry", 0, 0, mo);

    set_cfg(2, 2, 0);
    err_idx = 2;
    run_fetch(9'h010, 8'd8, "err3", 0, 0, mo);

    set_cfg(2, 2, 0);
    rty_idx.push_back(0); rty_always = 1'b1;
    run_fetch(9'h010, 8'd8, "rty_exhaust", 0, 0, mo);

    @(negedge clk_i);
    fetch_i = 1'b1; base_i = 9'h033; count_i = '0;
    @(negedge clk_i);
    fetch_i = 1'b0;
    check("zero_count ready", ready_o, 1'b1);
    check("zero_count bus", {cyc_o, stb_o, busy_o, error_o}, 4'b0000);
    @(negedge clk_i);
    check("zero_count pulse", {ready_o, cyc_o}, 2'b00);

    set_cfg(1, 2, 20);
    run_fetch(9'h1fc, 8'd8, "wrap", 0, 0, mo);

    set_cfg(1, 1, 0);
    run_fetch(ABITS'($urandom), 8'd255, "max_count", 0, 1, mo);

    for (int t = 0; t < 24; t++) begin
      cnt  = $urandom_range(1, 40);
      mode = $urandom_range(0, 3);
      set_cfg($urandom_range(1, 3), $urandom_range(3, 7), $urandom_range(0, 40));
      case (mode)
        1: repeat ($urandom_range(1, 3)) rty_idx.push_back($urandom_range(0, cnt - 1));
        2: err_idx = $urandom_range(0, cnt - 1);
        3: begin rty_idx.push_back($urandom_range(0, cnt - 1)); rty_always = 1'b1; end
        default: ;
      endcase
      run_fetch(ABITS'($urandom), LBITS'(cnt), $sformatf("rnd%0d", t), 0, 0, mo);
    end

    set_cfg(2, 2, 0);
    run_fetch(9'h040, 8'd20, "midburst_reset", 3, 0, mo);
    set_cfg(1, 3, 10);
    run_fetch(9'h080, 8'd8, "after_reset", 0, 0, mo);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
